// File: rtl/benes_route_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : benes_route_sequencer_pkg
// Description : Shared Benes network constants and switch-program types.
// Revision    : 1.0 - initial release
// ============================================================================
package benes_route_sequencer_pkg;

    localparam int SIZE            = 32;
    localparam int SWITCH_NUM      = SIZE / 2;
    localparam int DATA_WIDTH      = 64;
    localparam int BENES_STAGE_NUM = 2 * $clog2(SIZE) - 1;
    localparam int BENES_CFG_NUM   = 4;
    localparam int BENES_CFG_W     = $clog2(BENES_CFG_NUM);
    localparam int BENES_STG_W     = $clog2(BENES_STAGE_NUM);

    typedef logic [SWITCH_NUM-1:0]                  benes_stage_cfg_t;
    typedef benes_stage_cfg_t [BENES_STAGE_NUM-1:0] benes_prog_t;

endpackage
`default_nettype wire

// File: rtl/benes_route_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : benes_route_sequencer_if
// Description : Program-write, request and stage-drive bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface benes_route_sequencer_if #(
    parameter int SWITCH_NUM = benes_route_sequencer_pkg::SWITCH_NUM,
    parameter int NUM_STAGE  = benes_route_sequencer_pkg::BENES_STAGE_NUM,
    parameter int NUM_CFG    = benes_route_sequencer_pkg::BENES_CFG_NUM,
    parameter int CFG_W      = benes_route_sequencer_pkg::BENES_CFG_W,
    parameter int STG_W      = benes_route_sequencer_pkg::BENES_STG_W
) ();

    logic                            cfg_wr_en;
    logic [CFG_W-1:0]                cfg_wr_idx;
    logic [STG_W-1:0]                cfg_wr_stage;
    logic [SWITCH_NUM-1:0]           cfg_wr_data;
    logic                            cfg_wr_ready;
    logic                            req_valid;
    logic [CFG_W-1:0]                req_cfg_idx;
    logic                            req_ready;
    logic [NUM_STAGE*SWITCH_NUM-1:0] stage_switch_set;
    logic                            out_valid;
    logic [CFG_W-1:0]                out_cfg_idx;
    logic [NUM_CFG-1:0]              cfg_programmed;
    logic                            busy;
    logic                            err_unprog;

    modport master (
        output cfg_wr_en, cfg_wr_idx, cfg_wr_stage, cfg_wr_data,
        output req_valid, req_cfg_idx,
        input  cfg_wr_ready, req_ready, stage_switch_set, out_valid,
        input  out_cfg_idx, cfg_programmed, busy, err_unprog
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_idx, cfg_wr_stage, cfg_wr_data,
        input  req_valid, req_cfg_idx,
        output cfg_wr_ready, req_ready, stage_switch_set, out_valid,
        output out_cfg_idx, cfg_programmed, busy, err_unprog
    );

endinterface
`default_nettype wire

// File: rtl/benes_route_sequencer_cfg_table.sv
`default_nettype none
// ============================================================================
// Module      : benes_route_sequencer_cfg_table
// Description : Program register file, one write port, one read port per stage.
// Revision    : 1.0 - initial release
// ============================================================================
module benes_route_sequencer_cfg_table #(
    parameter int SWITCH_NUM = benes_route_sequencer_pkg::SWITCH_NUM,
    parameter int NUM_STAGE  = benes_route_sequencer_pkg::BENES_STAGE_NUM,
    parameter int NUM_CFG    = benes_route_sequencer_pkg::BENES_CFG_NUM,
    parameter int CFG_W      = benes_route_sequencer_pkg::BENES_CFG_W,
    parameter int STG_W      = benes_route_sequencer_pkg::BENES_STG_W
) (
    input  wire logic                            clk,
    input  wire logic                            rst_n,
    input  wire logic                            i_wr_en,
    input  wire logic [CFG_W-1:0]                i_wr_idx,
    input  wire logic [STG_W-1:0]                i_wr_stage,
    input  wire logic [SWITCH_NUM-1:0]           i_wr_data,
    input  wire logic [NUM_STAGE*CFG_W-1:0]      i_rd_idx,
    output logic      [NUM_STAGE*SWITCH_NUM-1:0] o_rd_data,
    output logic      [NUM_CFG-1:0]              o_programmed
);

    import benes_route_sequencer_pkg::*;

    logic [SWITCH_NUM-1:0] r_table   [NUM_CFG][NUM_STAGE];
    logic [NUM_STAGE-1:0]  r_written [NUM_CFG];

    // i_wr_en is already qualified by the caller, so the stage is in range here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CFG; c++) begin
                r_written[c] <= '0;
                for (int s = 0; s < NUM_STAGE; s++) begin
                    r_table[c][s] <= '0;
                end
            end
        end else if (i_wr_en) begin
            for (int c = 0; c < NUM_CFG; c++) begin
                for (int s = 0; s < NUM_STAGE; s++) begin
                    if (i_wr_idx == CFG_W'(c) && i_wr_stage == STG_W'(s)) begin
                        r_table[c][s]   <= i_wr_data;
                        r_written[c][s] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar s = 0; s < NUM_STAGE; s++) begin : g_rd
        assign o_rd_data[s*SWITCH_NUM +: SWITCH_NUM] = r_table[i_rd_idx[s*CFG_W +: CFG_W]][s];
    end

    for (genvar c = 0; c < NUM_CFG; c++) begin : g_prog
        assign o_programmed[c] = &r_written[c];
    end

endmodule
`default_nettype wire

// File: rtl/benes_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : benes_route_sequencer
// Description : Benes switch-program store; steers each vector's settings
//               stage by stage alongside it through the registered network.
// Revision    : 1.0 - initial release
// ============================================================================
module benes_route_sequencer #(
    parameter int SWITCH_NUM = benes_route_sequencer_pkg::SWITCH_NUM,
    parameter int NUM_STAGE  = benes_route_sequencer_pkg::BENES_STAGE_NUM,
    parameter int NUM_CFG    = benes_route_sequencer_pkg::BENES_CFG_NUM,
    parameter int CFG_W      = benes_route_sequencer_pkg::BENES_CFG_W,
    parameter int STG_W      = benes_route_sequencer_pkg::BENES_STG_W
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    benes_route_sequencer_if.slave   bus
);

    import benes_route_sequencer_pkg::*;

    logic                            w_wr_ok;
    logic                            w_req_ready;
    logic                            w_fire;
    logic [NUM_CFG-1:0]              w_inuse;
    logic [NUM_CFG-1:0]              w_programmed;
    logic [NUM_STAGE*CFG_W-1:0]      w_rd_idx;
    logic [NUM_STAGE*SWITCH_NUM-1:0] w_rd_data;
    logic [NUM_STAGE:1]              r_vld;
    logic [CFG_W-1:0]                r_idx [1:NUM_STAGE];
    logic                            r_err;

    always_comb begin
        w_inuse = '0;
        for (int s = 1; s <= NUM_STAGE; s++) begin
            if (r_vld[s]) begin
                w_inuse[r_idx[s]] = 1'b1;
            end
        end
    end

    // A same-cycle request only matters to a write of the same index, and then
    // the write wins, so the in-use check needs only the registered slots.
    assign w_wr_ok     = bus.cfg_wr_en && (bus.cfg_wr_stage < STG_W'(NUM_STAGE))
                         && !w_inuse[bus.cfg_wr_idx];
    assign w_req_ready = !(w_wr_ok && (bus.cfg_wr_idx == bus.req_cfg_idx));
    assign w_fire      = bus.req_valid && w_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_err <= 1'b0;
            for (int s = 1; s <= NUM_STAGE; s++) begin
                r_idx[s] <= '0;
            end
        end else begin
            r_vld[1] <= w_fire;
            r_idx[1] <= bus.req_cfg_idx;
            for (int s = 2; s <= NUM_STAGE; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_idx[s] <= r_idx[s-1];
            end
            if (w_fire && !w_programmed[bus.req_cfg_idx]) begin
                r_err <= 1'b1;
            end
        end
    end

    benes_route_sequencer_cfg_table #(
        .SWITCH_NUM (SWITCH_NUM),
        .NUM_STAGE  (NUM_STAGE),
        .NUM_CFG    (NUM_CFG),
        .CFG_W      (CFG_W),
        .STG_W      (STG_W)
    ) u_cfg_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (w_wr_ok),
        .i_wr_idx     (bus.cfg_wr_idx),
        .i_wr_stage   (bus.cfg_wr_stage),
        .i_wr_data    (bus.cfg_wr_data),
        .i_rd_idx     (w_rd_idx),
        .o_rd_data    (w_rd_data),
        .o_programmed (w_programmed)
    );

    // Slot 0 follows the live request; later slots follow the registered index.
    for (genvar s = 0; s < NUM_STAGE; s++) begin : g_slot
        logic w_act;
        if (s == 0) begin : g_head
            assign w_rd_idx[0 +: CFG_W] = bus.req_cfg_idx;
            assign w_act                = w_fire;
        end else begin : g_tail
            assign w_rd_idx[s*CFG_W +: CFG_W] = r_idx[s];
            assign w_act                      = r_vld[s];
        end
        assign bus.stage_switch_set[s*SWITCH_NUM +: SWITCH_NUM] =
            w_act ? w_rd_data[s*SWITCH_NUM +: SWITCH_NUM] : '0;
    end

    assign bus.cfg_wr_ready   = w_wr_ok;
    assign bus.req_ready      = w_req_ready;
    assign bus.out_valid      = r_vld[NUM_STAGE];
    assign bus.out_cfg_idx    = r_idx[NUM_STAGE];
    assign bus.cfg_programmed = w_programmed;
    assign bus.busy           = w_fire || (|r_vld);
    assign bus.err_unprog     = r_err;

endmodule
`default_nettype wire
